// File: rtl/fpmul_pkg.sv
// Shared constants for the multiplier scheduler: FSM state encoding and
// IEEE-754 single-precision field positions.
package fpmul_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int FP_SIGN     = 31;
    localparam int FP_EXP_MSB  = 30;
    localparam int FP_EXP_LSB  = 23;
    localparam int FP_MANT_MSB = 22;
    localparam int FP_BIAS     = 127;

endpackage

// File: rtl/control.sv
// Combinational single-precision multiply datapath. Always assumes an implicit
// leading one, truncates the mantissa and flags exponent overflow/underflow.
module control
    import fpmul_pkg::*;
(
    input  logic [31:0] inp1,
    input  logic [31:0] inp2,
    output logic [31:0] out,
    output logic        overflow,
    output logic        underflow
);

    logic [47:0]        prod_s;
    logic [22:0]        prod_unused_s;
    logic               norm_s;
    logic [22:0]        mant_s;
    logic signed [9:0]  exp_s;

    // Mantissa product, normalisation by at most one place, biased exponent sum.
    always_comb begin
        prod_s        = 48'({1'b1, inp1[FP_MANT_MSB:0]}) * 48'({1'b1, inp2[FP_MANT_MSB:0]});
        prod_unused_s = prod_s[22:0];
        norm_s        = prod_s[47];
        mant_s        = norm_s ? prod_s[46:24] : prod_s[45:23];
        exp_s         = $signed({2'b00, inp1[FP_EXP_MSB:FP_EXP_LSB]})
                      + $signed({2'b00, inp2[FP_EXP_MSB:FP_EXP_LSB]})
                      - $signed(10'(FP_BIAS))
                      + $signed({9'd0, norm_s});
        out           = {inp1[FP_SIGN] ^ inp2[FP_SIGN], exp_s[7:0], mant_s};
        overflow      = (exp_s > 10'sd254);
        underflow     = (exp_s < 10'sd1);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo NREQ. Outputs are don't-care (zero) when no request is set.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] pick_o,
    output logic [IDW-1:0]  idx_o
);

    // Rotating scan from the pointer; the first hit wins.
    always_comb begin
        int   j;
        logic found_s;
        pick_o  = '0;
        idx_o   = '0;
        found_s = 1'b0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (req_i[j] && !found_s) begin
                pick_o[j] = 1'b1;
                idx_o     = IDW'(j);
                found_s   = 1'b1;
            end else begin
                found_s   = found_s;
            end
        end
    end

endmodule

// File: rtl/fpmul_scheduler.sv
// Round-robin scheduler sharing one multicycle FP multiply datapath among
// NREQ requesters; results return with the requester ID over valid/ready.
module fpmul_scheduler
    import fpmul_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int LAT  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*32-1:0] a_in,
    input  logic [NREQ*32-1:0] b_in,
    output logic [NREQ-1:0]    gnt,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [31:0]        res_data,
    output logic [IDW-1:0]     res_id,
    output logic               res_ovf,
    output logic               res_unf,
    output logic               busy
);

    generate
        if (LAT < 1) begin : g_lat_check
            $error("fpmul_scheduler: LAT must be at least 1");
        end
    endgenerate

    localparam int CNTW = (LAT > 1) ? $clog2(LAT) : 1;

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [31:0]     op_a_q, op_a_d, op_b_q, op_b_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            res_valid_q, res_valid_d;
    logic [31:0]     res_data_q, res_data_d;
    logic [IDW-1:0]  res_id_q, res_id_d;
    logic            res_ovf_q, res_ovf_d, res_unf_q, res_unf_d;

    logic [NREQ-1:0] pick_s;
    logic [IDW-1:0]  idx_s;
    logic [31:0]     mul_out_s;
    logic            mul_ovf_s, mul_unf_s;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick_s),
        .idx_o  (idx_s)
    );

    // The datapath sees only the operand registers, so it may settle over LAT cycles.
    control u_mul (
        .inp1      (op_a_q),
        .inp2      (op_b_q),
        .out       (mul_out_s),
        .overflow  (mul_ovf_s),
        .underflow (mul_unf_s)
    );

    // Next-state logic for the grant / settle / handshake sequence.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        gnt_d       = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_ovf_d   = res_ovf_q;
        res_unf_d   = res_unf_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    op_a_d   = a_in[32*idx_s +: 32];
                    op_b_d   = b_in[32*idx_s +: 32];
                    res_id_d = idx_s;
                    gnt_d    = pick_s;
                    ptr_d    = (idx_s == IDW'(NREQ-1)) ? '0 : idx_s + IDW'(1);
                    cnt_d    = CNTW'(LAT-1);
                    state_d  = ST_WAIT;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d       = cnt_q - CNTW'(1);
                end else begin
                    res_data_d  = mul_out_s;
                    res_ovf_d   = mul_ovf_s;
                    res_unf_d   = mul_unf_s;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_DONE;
                end
            end
            default: begin
                res_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            op_a_q      <= 32'd0;
            op_b_q      <= 32'd0;
            gnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= 32'd0;
            res_id_q    <= '0;
            res_ovf_q   <= 1'b0;
            res_unf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            gnt_q       <= gnt_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_ovf_q   <= res_ovf_d;
            res_unf_q   <= res_unf_d;
        end
    end

    assign gnt       = gnt_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign res_ovf   = res_ovf_q;
    assign res_unf   = res_unf_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fpmul_scheduler.sv
// Self-checking bench for fpmul_scheduler: directed vector table, held-request
// and reset sequences, and randomized operations against a behavioural model.
module tb_fpmul_scheduler;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*32-1:0] a_in, b_in;
    logic [NREQ-1:0]    gnt;
    logic               res_valid, res_ready;
    logic [31:0]        res_data;
    logic [IDW-1:0]     res_id;
    logic               res_ovf, res_unf, busy;

    int n_cmp = 0;
    int n_bad = 0;
    int mptr  = 0;

    always #5 clk = ~clk;

    fpmul_scheduler #(.NREQ(NREQ), .IDW(IDW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .res_unf   (res_unf),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0]  rq;
        int          win;
        logic [31:0] a;
        logic [31:0] b;
        int          stall;
        logic [31:0] data;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference product: value-level arithmetic on the IEEE fields, truncating.
    function automatic logic [33:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        longint ma, mb, p;
        int     e;
        logic [31:0] m;
        logic [7:0]  e8;
        ma = longint'(a[22:0]) + (longint'(1) << 23);
        mb = longint'(b[22:0]) + (longint'(1) << 23);
        p  = ma * mb;
        e  = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (p >= (longint'(1) << 47)) begin
            e = e + 1;
            m = 32'(p >> 24);
        end else begin
            m = 32'(p >> 23);
        end
        e8 = 8'(e & 255);
        return {(e > 254), (e < 1), a[31] ^ b[31], e8, m[22:0]};
    endfunction

    function automatic int rr_pick(input logic [3:0] rq, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (rq[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic rand_operands();
        for (int i = 0; i < NREQ; i++) begin
            a_in[32*i +: 32] = $urandom;
            b_in[32*i +: 32] = $urandom;
        end
    endtask

    task automatic chk_zero_outs(input string tag);
        chk({tag, "_gnt"},   32'(gnt),       32'd0);
        chk({tag, "_valid"}, 32'(res_valid), 32'd0);
        chk({tag, "_data"},  res_data,       32'd0);
        chk({tag, "_id"},    32'(res_id),    32'd0);
        chk({tag, "_flags"}, 32'({res_ovf, res_unf}), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
    endtask

    // One full operation: request, grant, settle, optional stall, accept.
    task automatic do_op(input logic [3:0] rq, input int win, input int stall, input logic [33:0] ex);
        logic [NREQ-1:0] onehot;
        onehot      = '0;
        onehot[win] = 1'b1;
        @(negedge clk);
        req       = rq;
        res_ready = 1'b0;
        @(posedge clk); #1;
        chk("gnt", 32'(gnt), 32'(onehot));
        chk("busy_at_grant", 32'(busy), 32'd1);
        req[win] = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(posedge clk); #1;
            chk("gnt_one_cycle", 32'(gnt), 32'd0);
            if (k < LAT) chk("valid_early", 32'(res_valid), 32'd0);
        end
        chk("valid", 32'(res_valid), 32'd1);
        chk("data", res_data, ex[31:0]);
        chk("id", 32'(res_id), 32'(win));
        chk("ovf", 32'(res_ovf), 32'(ex[33]));
        chk("unf", 32'(res_unf), 32'(ex[32]));
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("hold_valid", 32'(res_valid), 32'd1);
            chk("hold_data", res_data, ex[31:0]);
            chk("hold_id_flags", 32'({res_ovf, res_unf, res_id}), 32'({ex[33], ex[32], 2'(win)}));
            chk("hold_no_gnt", 32'(gnt), 32'd0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        chk("accept_valid", 32'(res_valid), 32'd0);
        chk("accept_busy", 32'(busy), 32'd0);
        res_ready = 1'b0;
        mptr = (win + 1) % NREQ;
    endtask

    // Reset during WAIT: operation dropped, pending requests re-arbitrated from 0.
    task automatic reset_mid(input logic [3:0] first_rq, input int first_win,
                             input logic [3:0] pend_rq, input int pend_win);
        logic [NREQ-1:0] onehot;
        onehot            = '0;
        onehot[first_win] = 1'b1;
        rand_operands();
        @(negedge clk);
        req       = first_rq;
        res_ready = 1'b0;
        @(posedge clk); #1;
        chk("mid_first_gnt", 32'(gnt), 32'(onehot));
        req = '0;
        @(negedge clk);
        rst = 1'b1;
        req = pend_rq;
        #1;
        chk_zero_outs("mid_reset");
        @(posedge clk); #2;
        rst  = 1'b0;
        mptr = 0;
        chk("no_result_after_reset", 32'(res_valid), 32'd0);
        do_op(pend_rq, pend_win, 0, fmul_ref(a_in[32*pend_win +: 32], b_in[32*pend_win +: 32]));
    endtask

    initial begin
        logic [3:0]  rem;
        logic [3:0]  rq;
        int          w;

        vecs[0] = '{4'b0100, 2, 32'h40000000, 32'h40400000, 0, 32'h40C00000, 1'b0, 1'b0};
        vecs[1] = '{4'b0001, 0, 32'h7F000000, 32'h7F000000, 5, 32'h3E800000, 1'b1, 1'b0};
        vecs[2] = '{4'b0010, 1, 32'h00800000, 32'h00800000, 1, 32'h41800000, 1'b0, 1'b1};
        vecs[3] = '{4'b1001, 3, 32'h3FC00000, 32'h3FC00000, 0, 32'h40100000, 1'b0, 1'b0};
        vecs[4] = '{4'b1001, 0, 32'hC0000000, 32'h40400000, 2, 32'hC0C00000, 1'b0, 1'b0};
        vecs[5] = '{4'b1001, 3, 32'h3F800000, 32'h3F800000, 0, 32'h3F800000, 1'b0, 1'b0};
        vecs[6] = '{4'b1001, 0, 32'h40400000, 32'h40400000, 0, 32'h41100000, 1'b0, 1'b0};

        rst       = 1'b1;
        req       = '0;
        res_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        #1;
        chk_zero_outs("reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk_zero_outs("post_reset");

        rand_operands();
        rem = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            do_op(rem, i, 2, fmul_ref(a_in[32*i +: 32], b_in[32*i +: 32]));
            rem[i] = 1'b0;
        end

        for (int v = 0; v < 7; v++) begin
            rand_operands();
            a_in[32*vecs[v].win +: 32] = vecs[v].a;
            b_in[32*vecs[v].win +: 32] = vecs[v].b;
            do_op(vecs[v].rq, vecs[v].win, vecs[v].stall,
                  {vecs[v].ovf, vecs[v].unf, vecs[v].data});
        end

        for (int r = 0; r < 24; r++) begin
            rand_operands();
            rq = 4'($urandom_range(1, 15));
            w  = rr_pick(rq, mptr);
            do_op(rq, w, $urandom_range(0, 3), fmul_ref(a_in[32*w +: 32], b_in[32*w +: 32]));
        end

        reset_mid(4'b0001, 0, 4'b1000, 3);
        reset_mid(4'b0010, 1, 4'b0101, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
